// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous load, wrap/saturate mode
// and a combinational terminal count for chaining into wide or mixed-radix counters.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MODULUS - 1);
    localparam bit               FullRange = (longint'(MODULUS) == (longint'(1) << WIDTH));

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_clamped;
    logic             end_step;

    // With a full binary range every load_val is legal, so no clamp logic is built.
    if (FullRange) begin : g_no_clamp
        assign load_clamped = load_val;
    end else begin : g_clamp
        assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;
    end

    assign end_step = up ? (count_q == MaxVal) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (end_step) begin
                wrap_d = 1'b1;
                if (!SATURATE) begin
                    count_d = up ? '0 : MaxVal;
                end
            end else begin
                count_d = up ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    // Gated by clr so a reset counter held with en=1, up=0 does not fire the next stage.
    assign tc    = ~clr & en & ~load & end_step;

endmodule
